// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the memory controller slice.
//   state_t    - controller states (IDLE, RD_IF, RD_DM, WR_DM)
//   SZ_B/H/W   - data-access size codes (11 behaves as word)
//   size_to_n  - number of byte transfers for a size code
package cpu_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_DM = 2'd2,
    WR_DM = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;  // SZ_W and the reserved code 11
    endcase
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: collects read bytes from the byte-serial bus into a word.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   rdy        - global ready; low freezes all registers
//   clr        - restart assembly (counter and word cleared)
//   cap_en     - mem_din carries a valid read byte this cycle
//   n          - bytes expected for this access (1, 2 or 4)
//   din        - byte from memory
//   last       - this capture completes the access
//   word_next  - assembled word including the byte captured this cycle;
//                lanes >= n stay zero, giving zero-extension for free
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        cap_en,
  input  logic [2:0]  n,
  input  logic [7:0]  din,
  output logic        last,
  output logic [31:0] word_next
);

  logic [1:0]  cnt_reg;
  logic [31:0] data_reg;

  // Byte i of the access lands in lane i (little-endian).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_next[8*gi +: 8] = (cnt_reg == 2'(gi)) ? din : data_reg[8*gi +: 8];
  end

  assign last = cap_en && ({1'b0, cnt_reg} == (n - 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      data_reg <= '0;
    end else if (rdy) begin
      if (clr) begin
        cnt_reg  <= '0;
        data_reg <= '0;
      end else if (cap_en) begin
        cnt_reg  <= cnt_reg + 2'd1;
        data_reg <= word_next;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller serving instruction fetch (32-bit
// reads) and data access (byte/half/word loads and stores) on an 8-bit bus.
// Optional macro MEM_CTRL_PERF_EN adds perf_if_cycles / perf_dm_stall.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   rdy                      - global ready; low freezes every register
//   if_req/if_addr/if_flush  - fetch request, address, abort
//   if_done/if_data          - fetch completion pulse and word
//   dm_req/dm_we/dm_size/dm_addr/dm_wdata - data access request
//   dm_done/dm_rdata         - data completion pulse and zero-extended load
//   mem_din/mem_dout/mem_a/mem_wr - byte bus (outputs registered)
module mem_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter bit DM_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
`ifdef MEM_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_if_cycles,
  output logic [31:0]       perf_dm_stall
`endif
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [2:0]        n_reg, n_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [2:0]        cnt_reg, cnt_next;      // bytes issued so far
  logic              issue_reg, issue_next;  // mem_a holds a fresh read address
  logic              cap_reg, cap_next;      // mem_din holds a valid read byte
  logic [ADDR_W-1:0] mem_a_reg, mem_a_next;
  logic [7:0]        mem_dout_reg, mem_dout_next;
  logic              mem_wr_reg, mem_wr_next;
  logic              if_done_reg, if_done_next;
  logic              dm_done_reg, dm_done_next;
  logic [31:0]       if_data_reg, if_data_next;
  logic [31:0]       dm_rdata_reg, dm_rdata_next;

  logic        asm_last;
  logic [31:0] asm_word;
  logic        done_cycle, if_go, dm_go, pick_dm;

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clr       (state_reg == IDLE),
    .cap_en    (cap_reg),
    .n         (n_reg),
    .din       (mem_din),
    .last      (asm_last),
    .word_next (asm_word)
  );

  // Requests are still held high during the done cycle; they are only
  // sampled from the following cycle on.
  assign done_cycle = if_done_reg | dm_done_reg;
  assign if_go      = if_req && !if_flush && !done_cycle;
  assign dm_go      = dm_req && !done_cycle;
  assign pick_dm    = dm_go && (DM_PRIO || !if_go);

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    n_next        = n_reg;
    wdata_next    = wdata_reg;
    cnt_next      = cnt_reg;
    issue_next    = 1'b0;
    cap_next      = issue_reg;  // byte returns one cycle after its address
    mem_a_next    = mem_a_reg;
    mem_dout_next = mem_dout_reg;
    mem_wr_next   = 1'b0;
    if_done_next  = 1'b0;
    dm_done_next  = 1'b0;
    if_data_next  = if_data_reg;
    dm_rdata_next = dm_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (pick_dm) begin
          addr_next  = dm_addr;
          n_next     = size_to_n(dm_size);
          wdata_next = dm_wdata;
          mem_a_next = dm_addr;
          cnt_next   = 3'd1;
          if (dm_we) begin
            state_next    = WR_DM;
            mem_wr_next   = 1'b1;
            mem_dout_next = dm_wdata[7:0];
          end else begin
            state_next = RD_DM;
            issue_next = 1'b1;
          end
        end else if (if_go) begin
          addr_next  = if_addr;
          n_next     = 3'd4;
          mem_a_next = if_addr;
          cnt_next   = 3'd1;
          issue_next = 1'b1;
          state_next = RD_IF;
        end
      end

      RD_IF, RD_DM: begin
        if (state_reg == RD_IF && if_flush) begin
          // Drop the fetch: nothing more issued, in-flight byte ignored.
          state_next = IDLE;
          cap_next   = 1'b0;
        end else begin
          if (cnt_reg < n_reg) begin
            mem_a_next = addr_reg + ADDR_W'(cnt_reg);
            cnt_next   = cnt_reg + 3'd1;
            issue_next = 1'b1;
          end
          if (asm_last) begin
            state_next = IDLE;
            if (state_reg == RD_IF) begin
              if_done_next = 1'b1;
              if_data_next = asm_word;
            end else begin
              dm_done_next  = 1'b1;
              dm_rdata_next = asm_word;
            end
          end
        end
      end

      WR_DM: begin
        if (cnt_reg < n_reg) begin
          mem_a_next    = addr_reg + ADDR_W'(cnt_reg);
          mem_dout_next = wdata_reg[8*cnt_reg[1:0] +: 8];
          mem_wr_next   = 1'b1;
          cnt_next      = cnt_reg + 3'd1;
        end else begin
          dm_done_next = 1'b1;
          state_next   = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      n_reg        <= '0;
      wdata_reg    <= '0;
      cnt_reg      <= '0;
      issue_reg    <= 1'b0;
      cap_reg      <= 1'b0;
      mem_a_reg    <= '0;
      mem_dout_reg <= '0;
      mem_wr_reg   <= 1'b0;
      if_done_reg  <= 1'b0;
      dm_done_reg  <= 1'b0;
      if_data_reg  <= '0;
      dm_rdata_reg <= '0;
    end else if (rdy) begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      n_reg        <= n_next;
      wdata_reg    <= wdata_next;
      cnt_reg      <= cnt_next;
      issue_reg    <= issue_next;
      cap_reg      <= cap_next;
      mem_a_reg    <= mem_a_next;
      mem_dout_reg <= mem_dout_next;
      mem_wr_reg   <= mem_wr_next;
      if_done_reg  <= if_done_next;
      dm_done_reg  <= dm_done_next;
      if_data_reg  <= if_data_next;
      dm_rdata_reg <= dm_rdata_next;
    end
  end

  assign mem_a    = mem_a_reg;
  assign mem_dout = mem_dout_reg;
  assign mem_wr   = mem_wr_reg;
  assign if_done  = if_done_reg;
  assign dm_done  = dm_done_reg;
  assign if_data  = if_data_reg;
  assign dm_rdata = dm_rdata_reg;

`ifdef MEM_CTRL_PERF_EN
  logic [31:0] perf_if_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_reg    <= '0;
      perf_stall_reg <= '0;
    end else if (rdy) begin
      if (state_reg == RD_IF)
        perf_if_reg <= perf_if_reg + 32'd1;
      // A data request waiting for service (not its own done cycle).
      if (dm_req && state_reg != RD_DM && state_reg != WR_DM && !dm_done_reg)
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_if_cycles = perf_if_reg;
  assign perf_dm_stall  = perf_stall_reg;
`else
  // Counters and their ports are absent in this build.
`endif

endmodule
